mem_model_multi: RTL and testbench



---
 rtl/mem_model_pkg.sv | 30 +++
 rtl/mem_model_chan.sv | 100 ++++++++++
 rtl/mem_model_multi.sv | 105 ++++++++++
 tb/tb_mem_model_multi.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_model_pkg.sv
// Shared types and helpers for the multi-channel memory model.
// Holds the channel FSM state type and the parameter sanity check.
package mem_model_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_R,
        WAIT_W,
        RESP_R,
        RESP_W
    } state_t;

    // True when DEPTH fits in the address space and LATENCY is legal.
    function automatic bit params_ok(
        input int unsigned depth,
        input int unsigned addr_bits,
        input int unsigned latency
    );
        longint unsigned span;
        span = longint'(1) << addr_bits;
        return (depth >= 1) && (latency >= 1) &&
               (longint'(depth) <= span);
    endfunction

    // Width of the latency down-counter; never below one bit.
    function automatic int cnt_width(input int unsigned latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/mem_model_chan.sv
// One request channel: IDLE/WAIT/RESP sequencing and latency count.
// Ports: valid/address/data requests in, ready/read_data/addr_err out,
// latched addr/wdata plus rd_fire/wr_fire strobes to the shared array.
module mem_model_chan
    import mem_model_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16,
    parameter int LATENCY   = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 read_valid,
    input  logic [ADDR_BITS-1:0] read_address,
    input  logic                 write_valid,
    input  logic [ADDR_BITS-1:0] write_address,
    input  logic [DATA_BITS-1:0] write_data,
    input  logic [DATA_BITS-1:0] mem_rdata,
    input  logic                 in_range,
    output logic [ADDR_BITS-1:0] addr,
    output logic [DATA_BITS-1:0] wdata,
    output logic                 rd_fire,
    output logic                 wr_fire,
    output logic                 read_ready,
    output logic [DATA_BITS-1:0] read_data,
    output logic                 write_ready,
    output logic                 addr_err
);

    localparam int CW = cnt_width(LATENCY);
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    state_t        state;
    logic [CW-1:0] cnt;

    // Strobes mark the edge that enters RESP_x.
    assign rd_fire = (state == WAIT_R) && (cnt == '0);
    assign wr_fire = (state == WAIT_W) && (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            addr        <= '0;
            wdata       <= '0;
            read_ready  <= 1'b0;
            read_data   <= '0;
            write_ready <= 1'b0;
            addr_err    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (write_valid) begin
                        addr  <= write_address;
                        wdata <= write_data;
                        cnt   <= CNT_INIT;
                        state <= WAIT_W;
                    end else if (read_valid) begin
                        addr  <= read_address;
                        cnt   <= CNT_INIT;
                        state <= WAIT_R;
                    end
                end
                WAIT_R: begin
                    if (cnt == '0) begin
                        read_ready <= 1'b1;
                        read_data  <= mem_rdata;
                        if (!in_range) addr_err <= 1'b1;
                        state <= RESP_R;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WAIT_W: begin
                    if (cnt == '0) begin
                        write_ready <= 1'b1;
                        if (!in_range) addr_err <= 1'b1;
                        state <= RESP_W;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP_R: begin
                    if (!read_valid) begin
                        read_ready <= 1'b0;
                        state      <= IDLE;
                    end
                end
                RESP_W: begin
                    if (!write_valid) begin
                        write_ready <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mem_model_multi.sv
// Multi-channel fixed-latency memory model with backdoor preload.
// Ports: per-channel read/write valid-ready buses, load_* backdoor,
// sticky addr_err per channel, global read/write completion counters.
module mem_model_multi
    import mem_model_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 16,
    parameter int CHANNELS  = 4,
    parameter int DEPTH     = 256,
    parameter int LATENCY   = 2,
    parameter int CNT_BITS  = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [CHANNELS-1:0]                 read_valid,
    input  logic [CHANNELS-1:0][ADDR_BITS-1:0]  read_address,
    output logic [CHANNELS-1:0]                 read_ready,
    output logic [CHANNELS-1:0][DATA_BITS-1:0]  read_data,
    input  logic [CHANNELS-1:0]                 write_valid,
    input  logic [CHANNELS-1:0][ADDR_BITS-1:0]  write_address,
    input  logic [CHANNELS-1:0][DATA_BITS-1:0]  write_data,
    output logic [CHANNELS-1:0]                 write_ready,
    input  logic                                load_en,
    input  logic [ADDR_BITS-1:0]                load_addr,
    input  logic [DATA_BITS-1:0]                load_data,
    output logic [CHANNELS-1:0]                 addr_err,
    output logic [CNT_BITS-1:0]                 read_count,
    output logic [CNT_BITS-1:0]                 write_count
);

    if (!params_ok(DEPTH, ADDR_BITS, LATENCY)) begin : g_bad_params
        $error("mem_model_multi: illegal DEPTH/LATENCY");
    end

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_BITS:0] DEPTH_W = (ADDR_BITS + 1)'(DEPTH);

    logic [DATA_BITS-1:0] mem [DEPTH];

    logic [CHANNELS-1:0][ADDR_BITS-1:0] chan_addr;
    logic [CHANNELS-1:0][DATA_BITS-1:0] chan_wdata;
    logic [CHANNELS-1:0][DATA_BITS-1:0] mem_rdata;
    logic [CHANNELS-1:0]                in_range;
    logic [CHANNELS-1:0]                rd_fire;
    logic [CHANNELS-1:0]                wr_fire;
    logic                               load_ok;

    assign load_ok = ({1'b0, load_addr} < DEPTH_W);

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        assign in_range[ch] = ({1'b0, chan_addr[ch]} < DEPTH_W);
        // Combinational array read gives read-before-write ordering.
        assign mem_rdata[ch] = in_range[ch] ?
                               mem[chan_addr[ch][IW-1:0]] : '0;

        mem_model_chan #(
            .ADDR_BITS (ADDR_BITS),
            .DATA_BITS (DATA_BITS),
            .LATENCY   (LATENCY)
        ) u_chan (
            .clk           (clk),
            .reset         (reset),
            .read_valid    (read_valid[ch]),
            .read_address  (read_address[ch]),
            .write_valid   (write_valid[ch]),
            .write_address (write_address[ch]),
            .write_data    (write_data[ch]),
            .mem_rdata     (mem_rdata[ch]),
            .in_range      (in_range[ch]),
            .addr          (chan_addr[ch]),
            .wdata         (chan_wdata[ch]),
            .rd_fire       (rd_fire[ch]),
            .wr_fire       (wr_fire[ch]),
            .read_ready    (read_ready[ch]),
            .read_data     (read_data[ch]),
            .write_ready   (write_ready[ch]),
            .addr_err      (addr_err[ch])
        );
    end

    // Later assignments win: load first, then channels in ascending
    // order, so the highest channel beats both lower ones and load.
    always_ff @(posedge clk) begin
        if (load_en && load_ok) begin
            mem[load_addr[IW-1:0]] <= load_data;
        end
        for (int ch = 0; ch < CHANNELS; ch++) begin
            if (!reset && wr_fire[ch] && in_range[ch]) begin
                mem[chan_addr[ch][IW-1:0]] <= chan_wdata[ch];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            read_count  <= '0;
            write_count <= '0;
        end else begin
            read_count  <= read_count + CNT_BITS'($countones(rd_fire));
            write_count <= write_count + CNT_BITS'($countones(wr_fire));
        end
    end

endmodule

// File: tb/tb_mem_model_multi.sv
// Directed self-checking bench for mem_model_multi.
// LATENCY=2, DEPTH=128 so address 200 exercises the range error.
module tb_mem_model_multi;

    localparam int AB = 8;
    localparam int DB = 16;
    localparam int CH = 4;
    localparam int CB = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic [CH-1:0]      read_valid;
    logic [CH-1:0][AB-1:0] read_address;
    logic [CH-1:0]      read_ready;
    logic [CH-1:0][DB-1:0] read_data;
    logic [CH-1:0]      write_valid;
    logic [CH-1:0][AB-1:0] write_address;
    logic [CH-1:0][DB-1:0] write_data;
    logic [CH-1:0]      write_ready;
    logic               load_en;
    logic [AB-1:0]      load_addr;
    logic [DB-1:0]      load_data;
    logic [CH-1:0]      addr_err;
    logic [CB-1:0]      read_count;
    logic [CB-1:0]      write_count;

    int total = 0;
    int bad   = 0;

    mem_model_multi #(
        .ADDR_BITS (AB),
        .DATA_BITS (DB),
        .CHANNELS  (CH),
        .DEPTH     (128),
        .LATENCY   (2),
        .CNT_BITS  (CB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .read_valid    (read_valid),
        .read_address  (read_address),
        .read_ready    (read_ready),
        .read_data     (read_data),
        .write_valid   (write_valid),
        .write_address (write_address),
        .write_data    (write_data),
        .write_ready   (write_ready),
        .load_en       (load_en),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .addr_err      (addr_err),
        .read_count    (read_count),
        .write_count   (write_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset         = 1'b1;
        read_valid    = '0;
        read_address  = '0;
        write_valid   = '0;
        write_address = '0;
        write_data    = '0;
        load_en       = 1'b0;
        load_addr     = '0;
        load_data     = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_rready", 32'(read_ready), 32'h0);
        chk("rst_wready", 32'(write_ready), 32'h0);
        chk("rst_rdata0", 32'(read_data[0]), 32'h0);
        chk("rst_err", 32'(addr_err), 32'h0);
        chk("rst_rcnt", 32'(read_count), 32'h0);
        chk("rst_wcnt", 32'(write_count), 32'h0);

        // Backdoor preload addr 5.
        load_en = 1'b1; load_addr = 8'd5; load_data = 16'hBEEF;
        tick();
        load_en = 1'b0;

        // ch0 read addr 5: ready exactly two edges after accept.
        read_valid[0] = 1'b1; read_address[0] = 8'd5;
        tick();
        chk("r0_lat0", 32'(read_ready[0]), 32'h0);
        tick();
        chk("r0_lat1", 32'(read_ready[0]), 32'h0);
        tick();
        chk("r0_ready", 32'(read_ready[0]), 32'h1);
        chk("r0_data", 32'(read_data[0]), 32'hBEEF);
        chk("r0_rcnt", 32'(read_count), 32'h1);
        tick();
        chk("r0_hold", 32'(read_ready[0]), 32'h1);
        read_valid[0] = 1'b0;
        tick();
        chk("r0_drop", 32'(read_ready[0]), 32'h0);
        chk("r0_keep", 32'(read_data[0]), 32'hBEEF);

        // ch1 write 0x1234 to addr 9.
        write_valid[1] = 1'b1; write_address[1] = 8'd9;
        write_data[1] = 16'h1234;
        tick();
        tick();
        chk("w1_lat", 32'(write_ready[1]), 32'h0);
        tick();
        chk("w1_ready", 32'(write_ready[1]), 32'h1);
        chk("w1_wcnt", 32'(write_count), 32'h1);
        write_valid[1] = 1'b0;
        tick();
        chk("w1_drop", 32'(write_ready[1]), 32'h0);

        // ch2 read back addr 9.
        read_valid[2] = 1'b1; read_address[2] = 8'd9;
        tick(); tick(); tick();
        chk("r2_data", 32'(read_data[2]), 32'h1234);
        chk("r2_rcnt", 32'(read_count), 32'h2);
        read_valid[2] = 1'b0;
        tick();

        // ch0 and ch3 write addr 7 together: ch3 wins.
        write_valid[0] = 1'b1; write_address[0] = 8'd7;
        write_data[0] = 16'hAAAA;
        write_valid[3] = 1'b1; write_address[3] = 8'd7;
        write_data[3] = 16'h5555;
        tick(); tick(); tick();
        chk("w03_ready", 32'(write_ready), 32'h9);
        chk("w03_wcnt", 32'(write_count), 32'h3);
        write_valid = '0;
        tick();
        read_valid[1] = 1'b1; read_address[1] = 8'd7;
        tick(); tick(); tick();
        chk("w03_data", 32'(read_data[1]), 32'h5555);
        read_valid[1] = 1'b0;
        tick();

        // ch2 out-of-range read.
        read_valid[2] = 1'b1; read_address[2] = 8'd200;
        tick(); tick(); tick();
        chk("oor_ready", 32'(read_ready[2]), 32'h1);
        chk("oor_data", 32'(read_data[2]), 32'h0);
        chk("oor_err", 32'(addr_err), 32'h4);
        read_valid[2] = 1'b0;
        tick();
        chk("oor_drop", 32'(read_ready[2]), 32'h0);
        chk("oor_sticky", 32'(addr_err), 32'h4);

        // ch0 read and write together: write first, then read.
        read_valid[0] = 1'b1; read_address[0] = 8'h20;
        write_valid[0] = 1'b1; write_address[0] = 8'h20;
        write_data[0] = 16'h7777;
        tick(); tick(); tick();
        chk("rw_wready", 32'(write_ready[0]), 32'h1);
        chk("rw_rbusy", 32'(read_ready[0]), 32'h0);
        write_valid[0] = 1'b0;
        tick();
        chk("rw_wdrop", 32'(write_ready[0]), 32'h0);
        tick(); tick();
        chk("rw_rlat", 32'(read_ready[0]), 32'h0);
        tick();
        chk("rw_rready", 32'(read_ready[0]), 32'h1);
        chk("rw_rdata", 32'(read_data[0]), 32'h7777);
        read_valid[0] = 1'b0;
        tick();

        // ch3 drops valid during WAIT: one-cycle ready pulse.
        read_valid[3] = 1'b1; read_address[3] = 8'd5;
        tick();
        read_valid[3] = 1'b0;
        tick(); tick();
        chk("pulse_hi", 32'(read_ready[3]), 32'h1);
        chk("pulse_data", 32'(read_data[3]), 32'hBEEF);
        tick();
        chk("pulse_lo", 32'(read_ready[3]), 32'h0);

        // ch1 write and load to the same address on one edge.
        write_valid[1] = 1'b1; write_address[1] = 8'h11;
        write_data[1] = 16'h2222;
        tick(); tick();
        load_en = 1'b1; load_addr = 8'h11; load_data = 16'h9999;
        tick();
        load_en = 1'b0;
        chk("wl_ready", 32'(write_ready[1]), 32'h1);
        write_valid[1] = 1'b0;
        tick();
        read_valid[0] = 1'b1; read_address[0] = 8'h11;
        tick(); tick(); tick();
        chk("wl_data", 32'(read_data[0]), 32'h2222);
        chk("cnt_r", 32'(read_count), 32'h7);
        chk("cnt_w", 32'(write_count), 32'h5);
        read_valid[0] = 1'b0;
        tick();

        // Reset during WAIT_R aborts without a ready pulse.
        read_valid[1] = 1'b1; read_address[1] = 8'd5;
        tick();
        reset = 1'b1;
        tick();
        chk("mr_ready", 32'(read_ready[1]), 32'h0);
        chk("mr_rcnt", 32'(read_count), 32'h0);
        chk("mr_wcnt", 32'(write_count), 32'h0);
        chk("mr_err", 32'(addr_err), 32'h0);
        reset = 1'b0;
        tick();
        chk("mr_lat0", 32'(read_ready[1]), 32'h0);
        tick();
        chk("mr_lat1", 32'(read_ready[1]), 32'h0);
        tick();
        chk("mr_ready2", 32'(read_ready[1]), 32'h1);
        chk("mr_data", 32'(read_data[1]), 32'hBEEF);
        chk("mr_rcnt2", 32'(read_count), 32'h1);
        read_valid[1] = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
